// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RV32I funct3 codes, alignment rules.
// Under MISALIGN_TRAP_EN the SPLIT state does not exist.
package lsu_pkg;

`ifdef MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ALIGNED = 2'd1,
        RESP    = 2'd3
    } lsu_state_t;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ALIGNED = 2'd1,
        SPLIT   = 2'd2,
        RESP    = 2'd3
    } lsu_state_t;
`endif

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3[1:0] == 2'b11) || (f3[2:1] == 2'b11);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b01:   return a[0];
            2'b10:   return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Index of the final byte access when a halfword or word is split.
    function automatic logic [1:0] last_idx(input logic [2:0] f3);
        return f3[1] ? 2'd3 : 2'd1;
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load-data extension: sign/zero extends from bit 7 or 15 according to funct3; combinational, 0 latency.
// No flow control.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic sgn;

    always_comb begin
        sgn = ~funct3_i[2];
        case (funct3_i[1:0])
            LB[1:0]: data_o = {{24{sgn & data_i[7]}},  data_i[7:0]};
            LH[1:0]: data_o = {{16{sgn & data_i[15]}}, data_i[15:0]};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: latency 1 (error), 2 (aligned), N+1 (split byte accesses); one request in flight,
// req_ready only when idle, response held until resp_ready. MISALIGN_TRAP_EN traps misaligned accesses instead of splitting.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_w_en,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] ext_in, ext_out;

`ifdef MISALIGN_TRAP_EN
    assign ext_in = mem_rdata;
`else
    logic [1:0]  idx_q, idx_d;
    logic [31:0] buf_q, buf_d, buf_merged;

    // Buffer with this cycle's byte already in its lane, so the last byte can be extended directly.
    always_comb begin
        buf_merged = buf_q;
        buf_merged[{idx_q, 3'b000} +: 8] = mem_rdata[7:0];
    end

    assign ext_in = (state_q == SPLIT) ? buf_merged : mem_rdata;
`endif

    lsu_extend u_extend (
        .data_i   (ext_in),
        .funct3_i (f3_q),
        .data_o   (ext_out)
    );

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        f3_d       = f3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
`ifndef MISALIGN_TRAP_EN
        idx_d      = idx_q;
        buf_d      = buf_q;
`endif
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        mem_w_en   = 1'b0;
        mem_funct3 = 3'b000;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
`ifndef MISALIGN_TRAP_EN
                    idx_d   = 2'd0;
                    buf_d   = 32'd0;
`endif
                    if (f3_illegal(req_funct3)) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end else if (misaligned(req_funct3, req_addr[1:0])) begin
`ifdef MISALIGN_TRAP_EN
                        state_d = RESP;
                        err_d   = 1'b1;
`else
                        state_d = SPLIT;
`endif
                    end else begin
                        state_d = ALIGNED;
                    end
                end
            end
            ALIGNED: begin
                mem_addr   = addr_q;
                mem_wdata  = wdata_q;
                mem_w_en   = we_q;
                mem_funct3 = f3_q;
                rdata_d    = we_q ? 32'd0 : ext_out;
                state_d    = RESP;
            end
`ifndef MISALIGN_TRAP_EN
            SPLIT: begin
                mem_addr   = addr_q + {30'd0, idx_q};
                mem_wdata  = {24'd0, wdata_q[{idx_q, 3'b000} +: 8]};
                mem_w_en   = we_q;
                mem_funct3 = we_q ? SB : LBU;
                buf_d      = buf_merged;
                if (idx_q == last_idx(f3_q)) begin
                    rdata_d = we_q ? 32'd0 : ext_out;
                    state_d = RESP;
                end else begin
                    idx_d   = idx_q + 2'd1;
                end
            end
`endif
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
`ifndef MISALIGN_TRAP_EN
            idx_q   <= 2'd0;
            buf_q   <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifndef MISALIGN_TRAP_EN
            idx_q   <= idx_d;
            buf_q   <= buf_d;
`endif
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array reference model, randomized and directed loads/stores.
// Responses are checked by an independent negedge monitor against a queue of expectations.
module tb_load_store_unit;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_w_en;
    logic [2:0]  mem_funct3;

    load_store_unit dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_w_en(mem_w_en),
        .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- memories: DUT-facing and reference ----------------
    logic [7:0] mem     [int unsigned];
    logic [7:0] ref_mem [int unsigned];
    int wr_cnt = 0;

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction
    function automatic logic [7:0] rd_mem(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction
    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    always @(mem_addr, wr_cnt)
        mem_rdata = {rd_mem(mem_addr + 32'd3), rd_mem(mem_addr + 32'd2),
                     rd_mem(mem_addr + 32'd1), rd_mem(mem_addr)};

    logic        p_en = 1'b0;
    logic [31:0] p_addr, p_data;
    logic [2:0]  p_f3;
    always @(negedge clock) begin
        p_en   = mem_w_en;
        p_addr = mem_addr;
        p_data = mem_wdata;
        p_f3   = mem_funct3;
    end
    always @(posedge clock) begin
        if (p_en && !reset) begin
            for (int i = 0; i < (1 << p_f3[1:0]); i++)
                mem[p_addr + 32'(i)] = p_data[8*i +: 8];
            wr_cnt++;
        end
    end

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        mem[a]     = d;
        ref_mem[a] = d;
        wr_cnt++;
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;
    exp_t q[$];
    logic cur_store_ok = 1'b0;

    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output exp_t e);
        int     nb;
        bit     illegal, mis;
        longint v;
        nb      = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        illegal = (f3[1:0] == 2'b11) || (f3 == 3'b110) || (f3 == 3'b111);
        mis     = (addr % nb) != 0;
        e.rd  = 32'd0;
        e.err = 1'b0;
        if (illegal || (mis && TRAP)) begin
            e.err = 1'b1;
            e.lat = 1;
        end else begin
            e.lat = mis ? nb + 1 : 2;
            if (we) begin
                for (int i = 0; i < nb; i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < nb; i++) v = v | (longint'(ref_rd(addr + 32'(i))) << (8*i));
                if (!f3[2] && nb < 4 && v[8*nb-1]) v = v - (longint'(1) << (8*nb));
                e.rd = v[31:0];
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        exp_t e;
        int   waitc = 0;
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        while (!req_ready) begin
            @(negedge clock);
            waitc++;
            if (waitc > 300) begin
                checks++; errors++;
                $display("FAIL issue_timeout: req_ready still 0 after %0d cycles, required 1", waitc);
                req_valid = 1'b0;
                return;
            end
        end
        model(we, f3, addr, wdata, e);
        e.acc = cyc + 1;
        q.push_back(e);
        cur_store_ok = we && !e.err;
        @(negedge clock);
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || resp_valid) && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (n >= 500) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", q.size());
        end
    endtask

    // ---------------- monitor / response side ----------------
    bit in_resp  = 1'b0;
    bit hold_req = 1'b0;
    bit rr_rand  = 1'b0;
    int hold_left = 0;

    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            in_resp = 1'b0;
        end else begin
            if (resp_valid && !in_resp && hold_req) begin
                hold_left = 5;
                hold_req  = 1'b0;
            end
            if (hold_left > 0) begin
                resp_ready = 1'b0;
                hold_left--;
            end else begin
                resp_ready = rr_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (mem_w_en) chk("mem_w_en_only_for_good_store", 32'(mem_w_en), 32'(cur_store_ok));
            if (resp_valid) begin
                chk("req_ready_low_in_resp", 32'(req_ready), 32'd0);
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp: resp_valid=1 with no request outstanding");
                end else begin
                    e = q[0];
                    if (!in_resp) chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                    in_resp = 1'b1;
                    chk("resp_rdata", resp_rdata, e.rd);
                    chk("resp_err", 32'(resp_err), 32'(e.err));
                    if (resp_ready) begin
                        void'(q.pop_front());
                        in_resp = 1'b0;
                    end
                end
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_resp_err"},   32'(resp_err), 32'd0);
        chk({tag, "_mem_w_en"},   32'(mem_w_en), 32'd0);
        chk({tag, "_mem_addr"},   mem_addr, 32'd0);
        chk({tag, "_mem_wdata"},  mem_wdata, 32'd0);
        chk({tag, "_mem_funct3"}, 32'(mem_funct3), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] old3, old4;
        logic [31:0] a;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1;
        #12;
        chk_reset_outputs("reset");
        @(negedge clock);
        reset = 1'b0;
        #1 chk("req_ready_after_reset", 32'(req_ready), 32'd1);
        @(negedge clock);

        // aligned word load
        poke(32'h100, 8'hEF); poke(32'h101, 8'hBE); poke(32'h102, 8'hAD); poke(32'h103, 8'hDE);
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        drain();
        // misaligned halfword, signed then unsigned
        poke(32'h101, 8'h34); poke(32'h102, 8'h92);
        issue(1'b0, 3'b001, 32'h101, 32'h0);
        issue(1'b0, 3'b101, 32'h101, 32'h0);
        // split store then split load back
        issue(1'b1, 3'b010, 32'h203, 32'h11223344);
        issue(1'b0, 3'b010, 32'h203, 32'h0);
        // illegal codes, loads and stores
        issue(1'b0, 3'b011, 32'h100, 32'h0);
        issue(1'b1, 3'b011, 32'h100, 32'hCAFEF00D);
        issue(1'b1, 3'b110, 32'h104, 32'hCAFEF00D);
        issue(1'b0, 3'b111, 32'h104, 32'h0);
        // misaligned halfword store (traps in trap build)
        issue(1'b1, 3'b001, 32'h001, 32'h0000BEEF);
        issue(1'b0, 3'b100, 32'h102, 32'h0);
        drain();
        // response held off while a new request waits
        hold_req = 1'b1;
        issue(1'b0, 3'b010, 32'h100, 32'h0);
        issue(1'b0, 3'b000, 32'h102, 32'h0);
        drain();
        // address wrap
        issue(1'b1, 3'b010, 32'hFFFFFFFE, 32'hA1B2C3D4);
        issue(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
        issue(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0);
        drain();

        // reset during a split store
        old3 = ref_rd(32'h303);
        old4 = ref_rd(32'h304);
        issue(1'b1, 3'b010, 32'h301, 32'h44332211);
        if (!TRAP) begin
            @(negedge clock);
            @(negedge clock);
            reset = 1'b1;
            #1 chk_reset_outputs("mid_split_reset");
            q.delete();
            ref_mem[32'h303] = old3;
            ref_mem[32'h304] = old4;
            chk("split_reset_b0", 32'(rd_mem(32'h301)), 32'h11);
            chk("split_reset_b1", 32'(rd_mem(32'h302)), 32'h22);
            chk("split_reset_b2", 32'(rd_mem(32'h303)), 32'(old3));
            chk("split_reset_b3", 32'(rd_mem(32'h304)), 32'(old4));
            @(negedge clock);
            reset = 1'b0;
            @(negedge clock);
        end
        drain();

        // randomized traffic with random backpressure
        rr_rand = 1'b1;
        for (int n = 0; n < 400; n++) begin
            a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                            : 32'h400 + 32'($urandom_range(0, 15));
            issue(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom);
        end
        drain();

        foreach (mem[k])     chk($sformatf("mem_%08h", k), 32'(rd_mem(k)), 32'(ref_rd(k)));
        foreach (ref_mem[k]) chk($sformatf("ref_%08h", k), 32'(rd_mem(k)), 32'(ref_rd(k)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
